// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle multiply and taken-branch squash.
// Enables and flushes are combinational from hazard inputs and FSM state; stall_cnt counts pc_en=0 cycles.
module pipeline_hazard_ctrl #(
   parameter int MULT_LAT = 3,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_mult,
   input  logic             mem_branch_taken,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mult_busy,
   output logic             mult_done,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {IDLE, MULT_WAIT} state_t;

   localparam logic [3:0] LAST_CNT = 4'(MULT_LAT - 1);
   localparam bit         MULTI    = (MULT_LAT > 1);

   state_t             state_q, state_d;
   logic [3:0]         mcnt_q, mcnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic final_cyc;
   logic mult_stall;

   always_comb begin
      load_use = ex_memread && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      // A single-cycle multiply finishes in the cycle it enters EX.
      if (MULTI)
         final_cyc = (state_q == MULT_WAIT) && (mcnt_q == LAST_CNT);
      else
         final_cyc = ex_is_mult;
      mult_stall = ex_is_mult && !final_cyc;

      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mult_done    = 1'b0;
      mult_busy    = 1'b0;

      if (!rst) begin
         mult_busy = (state_q == MULT_WAIT);
         if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else begin
            mult_done = final_cyc && ex_is_mult;
            if (mult_stall) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_en     = 1'b0;
               ex_mem_flush = 1'b1;
            end else if (load_use) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
      end

      state_d = state_q;
      mcnt_d  = mcnt_q;
      if (mem_branch_taken) begin
         state_d = IDLE;
         mcnt_d  = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ex_is_mult && MULTI) begin
                  state_d = MULT_WAIT;
                  mcnt_d  = 4'd1;
               end
            end
            MULT_WAIT: begin
               if (mcnt_q == LAST_CNT) begin
                  state_d = IDLE;
                  mcnt_d  = 4'd0;
               end else begin
                  mcnt_d = mcnt_q + 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               mcnt_d  = 4'd0;
            end
         endcase
      end

      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~pc_en};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mcnt_q      <= 4'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mcnt_q      <= mcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: two instances (MULT_LAT=3/CNT_W=4 and MULT_LAT=1/CNT_W=32) against a cycle-level hazard model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_memread, ex_is_mult, mem_branch_taken;

   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, busy, done}
   wire [9:0]  out0, out1;
   wire [3:0]  cnt0;
   wire [31:0] cnt1;

   int total = 0;
   int bad   = 0;

   int          age [2];
   logic [31:0] mcnt [2];
   logic [9:0]  s0;
   logic [3:0]  scnt0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MULT_LAT(3), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .ex_is_mult(ex_is_mult), .mem_branch_taken(mem_branch_taken),
      .pc_en(out0[9]), .if_id_en(out0[8]), .id_ex_en(out0[7]), .ex_mem_en(out0[6]),
      .mem_wb_en(out0[5]), .if_id_flush(out0[4]), .id_ex_flush(out0[3]),
      .ex_mem_flush(out0[2]), .mult_busy(out0[1]), .mult_done(out0[0]), .stall_cnt(cnt0)
   );

   pipeline_hazard_ctrl #(.MULT_LAT(1), .CNT_W(32)) u1 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .ex_is_mult(ex_is_mult), .mem_branch_taken(mem_branch_taken),
      .pc_en(out1[9]), .if_id_en(out1[8]), .id_ex_en(out1[7]), .ex_mem_en(out1[6]),
      .mem_wb_en(out1[5]), .if_id_flush(out1[4]), .id_ex_flush(out1[3]),
      .ex_mem_flush(out1[2]), .mult_busy(out1[1]), .mult_done(out1[0]), .stall_cnt(cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
      ex_is_mult = 1'b0; mem_branch_taken = 1'b0;
   endtask

   // One clock: check both instances at the falling edge, then advance the model.
   task automatic cycle();
      logic       lu, fin;
      logic [4:0] en;
      logic [2:0] fl;
      logic [9:0] e;
      int         lat;
      @(negedge clk);
      lu = ex_memread && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      for (int k = 0; k < 2; k++) begin
         lat = (k == 0) ? 3 : 1;
         fin = ex_is_mult && (age[k] == lat - 1);
         en  = 5'b11111;
         fl  = 3'b000;
         if (!rst) begin
            if (mem_branch_taken)            fl = 3'b111;
            else if (ex_is_mult && !fin)     begin en = 5'b00011; fl = 3'b001; end
            else if (lu)                     begin en = 5'b00111; fl = 3'b010; end
         end
         e = {en, fl, (!rst && age[k] > 0), (!rst && !mem_branch_taken && fin)};
         if (k == 0) begin
            chk("outs_lat3", {22'd0, out0}, {22'd0, e});
            chk("cnt_lat3", {28'd0, cnt0}, mcnt[0] & 32'hF);
            s0 = out0; scnt0 = cnt0;
         end else begin
            chk("outs_lat1", {22'd0, out1}, {22'd0, e});
            chk("cnt_lat1", cnt1, mcnt[1]);
         end
         if (rst) begin
            age[k] = 0; mcnt[k] = 0;
         end else begin
            if (!en[4]) mcnt[k] = mcnt[k] + 1;
            if (mem_branch_taken || fin) age[k] = 0;
            else if (ex_is_mult)         age[k] = age[k] + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      age[0] = 0; age[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
      idle();
      // Reset with hazards present on the inputs
      rst = 1'b1; ex_is_mult = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      cycle();
      chk("rst_pc_en", {31'd0, s0[9]}, 32'd1);
      chk("rst_flush", {29'd0, s0[4:2]}, 32'd0);
      cycle();
      chk("rst_busy", {31'd0, s0[1]}, 32'd0);
      idle(); cycle();
      chk("rst_cnt", {28'd0, scnt0}, 32'd0);

      // Load-use on rs2
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      cycle();
      chk("lu_pc_en", {31'd0, s0[9]}, 32'd0);
      chk("lu_if_id_en", {31'd0, s0[8]}, 32'd0);
      chk("lu_id_ex_flush", {31'd0, s0[3]}, 32'd1);
      idle(); cycle();
      chk("lu_cnt", {28'd0, scnt0}, 32'd1);
      // x0 destination is never a hazard
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
      cycle();
      chk("lu_x0_pc_en", {31'd0, s0[9]}, 32'd1);

      // Three-cycle multiply
      idle(); ex_is_mult = 1'b1;
      cycle();
      chk("mul1_pc_en", {31'd0, s0[9]}, 32'd0);
      chk("mul1_exmem_flush", {31'd0, s0[2]}, 32'd1);
      cycle();
      chk("mul2_busy", {31'd0, s0[1]}, 32'd1);
      cycle();
      chk("mul3_done", {31'd0, s0[0]}, 32'd1);
      chk("mul3_pc_en", {31'd0, s0[9]}, 32'd1);
      idle(); cycle();
      chk("mul_cnt", {28'd0, scnt0}, 32'd3);

      // Branch squashes a multiply in its second cycle
      ex_is_mult = 1'b1; cycle();
      mem_branch_taken = 1'b1; cycle();
      chk("br_mul_en_fl", {24'd0, s0[9:2]}, 32'hFF);
      chk("br_mul_done", {31'd0, s0[0]}, 32'd0);
      idle(); cycle();
      chk("br_mul_idle", {31'd0, s0[1]}, 32'd0);
      chk("br_mul_cnt", {28'd0, scnt0}, 32'd4);

      // Branch outranks load-use
      ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; mem_branch_taken = 1'b1;
      cycle();
      chk("br_lu_pc_en", {31'd0, s0[9]}, 32'd1);
      chk("br_lu_flush", {29'd0, s0[4:2]}, 32'd7);
      idle(); cycle();
      chk("br_lu_cnt", {28'd0, scnt0}, 32'd4);

      // Counter wrap on the 4-bit instance
      rst = 1'b1; cycle();
      idle(); ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      for (int i = 0; i < 17; i++) cycle();
      idle(); cycle();
      chk("wrap_cnt", {28'd0, scnt0}, 32'd1);

      // Random traffic; a multiply in flight keeps EX occupied
      for (int i = 0; i < 3000; i++) begin
         rst              = ($urandom_range(0, 59) == 0);
         ex_rd            = 5'($urandom_range(0, 3));
         id_rs1           = 5'($urandom_range(0, 3));
         id_rs2           = 5'($urandom_range(0, 3));
         id_use_rs1       = 1'($urandom_range(0, 1));
         id_use_rs2       = 1'($urandom_range(0, 1));
         ex_memread       = ($urandom_range(0, 2) == 0);
         mem_branch_taken = ($urandom_range(0, 7) == 0);
         ex_is_mult       = (age[0] > 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline with the 3-cycle multiplier. It watches decode, execute and memory-stage hazard information. It drives the enable inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus per-stage flush (bubble) strobes. It covers load-use hazards, multi-cycle multiply occupancy of EX, and taken-branch squashing, and keeps a free-running stall-cycle counter for performance measurement.

## Interface
- MULT_LAT, 3, cycles a multiply occupies EX (legal 1..15)
- CNT_W, 32, width of stall performance counter
- clk  in  1  pipeline clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  instruction in ID actually reads that source
- ex_memread  in  1  instruction in EX (ID/EX output) is a load
- ex_rd  in  5  destination register of instruction in EX
- ex_is_mult  in  1  instruction in EX is a multiply
- mem_branch_taken  in  1  branch in MEM resolved taken (membranch & zero from EX/MEM)
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (control bits zero) into that register this edge
- mult_busy  out  1  multiplier FSM in MULT_WAIT
- mult_done  out  1  one-cycle pulse on the final EX cycle of a multiply
- stall_cnt  out  CNT_W  count of cycles with pc_en=0

## Operation
- FSM states: IDLE, MULT_WAIT; internal counter mcnt (4 bits).
- IDLE -> MULT_WAIT when ex_is_mult=1, MULT_LAT>1, mem_branch_taken=0; mcnt<=1.
- MULT_WAIT: mcnt increments each cycle; when mcnt==MULT_LAT-1, the cycle is the final EX cycle: mult_done=1, next state IDLE, mcnt<=0.
- MULT_LAT==1: FSM never leaves IDLE; mult_done=1 combinationally whenever ex_is_mult=1.
- mult_stall = ex_is_mult & ~(final EX cycle). While asserted: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1 (bubble into EX/MEM), mem_wb_en=1.
- load_use = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). While asserted and no mult_stall: pc_en=if_id_en=0, id_ex_flush=1; all other enables 1.
- Priority: mem_branch_taken > mult_stall > load_use > normal.
- mem_branch_taken=1: all enables 1; if_id_flush=id_ex_flush=ex_mem_flush=1; FSM forced to IDLE, mcnt<=0 (squashed multiply aborted); no stall counted.
- Normal: all enables 1, all flushes 0.
- Flush outputs are only asserted with the matching enable at 1.
- stall_cnt increments by 1 each cycle pc_en=0, wraps 2^CNT_W-1 -> 0.

## Timing
- Reset (rst=1 at edge): state IDLE, mcnt=0, stall_cnt=0. Combinational outputs follow inputs in the reset cycle. During reset, enables are all 1, flushes all 0, and mult_busy=0, mult_done=0 regardless of inputs.
- Enables/flushes are combinational from inputs and state (same-cycle); the datapath samples them at the next edge.
- A multiply entering EX at cycle N holds EX for cycles N..N+MULT_LAT-1. PC/IF/ID/ID/EX are frozen for MULT_LAT-1 edges, and EX/MEM receives MULT_LAT-1 bubbles then the product.
- Load-use inserts exactly one bubble. The dependent instruction re-evaluates next cycle with ex_memread=0.
- Reset asserted mid-multiply returns to IDLE at that edge; no mult_done emitted.
- Back-to-back multiplies: the second enters EX the cycle after mult_done, and the FSM re-enters MULT_WAIT immediately.

## Test plan
- Reset: rst=1 with ex_is_mult=1, ex_memread=1 -> all enables 1, flushes 0, stall_cnt=0, mult_busy=0.
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Same with ex_rd=0 -> no stall.
- Multiply MULT_LAT=3: ex_is_mult held 3 cycles -> 2 cycles stall with ex_mem_flush=1, mult_busy in cycles 2-3, mult_done on cycle 3, stall_cnt=2.
- Branch during multiply: mem_branch_taken=1 in 2nd multiply cycle -> three flushes=1, enables=1, FSM IDLE next cycle, no mult_done.
- Branch + load-use same cycle -> flush behaviour only, pc_en=1, stall_cnt unchanged.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cnt=1.
